// File: rtl/seg_cmd_ctrl.sv
// Command parser and multiplexed 7-segment driver fed by already-synchronised SPI bytes.
// Latency: buffer writes land on the rx_valid edge; seg/dp/dig_en follow one clk later.
// Backpressure: none. Every rx_valid byte is consumed in the cycle it is presented.
//
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   frame_start  one-cycle pulse at chip-select assertion; aborts a partial command
//   rx_valid     one-cycle strobe qualifying rx_data
//   rx_data      received byte (command or data)
//   seg, dp      registered segment bus {g,f,e,d,c,b,a} and decimal point, active high
//   dig_en       registered one-hot digit enable, active high, gated by the enable mask
//   cmd_err      sticky protocol error flag
module seg_cmd_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  cmd_err
);

  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNTW = $clog2(SCAN_DIV);

  localparam logic [3:0] OP_CLEAR_ERR = 4'h0;
  localparam logic [3:0] OP_WRITE_RAW = 4'h1;
  localparam logic [3:0] OP_WRITE_HEX = 4'h2;
  localparam logic [3:0] OP_BLANK_ALL = 4'h3;
  localparam logic [3:0] OP_SET_MASK  = 4'h4;

  typedef enum logic {IDLE, WAIT_DATA} state_t;

  state_t                state;
  logic [3:0]            lat_op;
  logic [3:0]            lat_idx;
  logic [7:0]            digit_buf [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] mask;
  logic [IDXW-1:0]       scan_idx;
  logic [CNTW-1:0]       scan_cnt;
  logic                  idx_ok;

  // The command index field is 4 bits wide; digits beyond NUM_DIGITS do not exist.
  assign idx_ok = ({28'd0, lat_idx} < NUM_DIGITS);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Parser FSM plus the state it owns (buffers, mask, error flag).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_op  <= 4'h0;
      lat_idx <= 4'h0;
      mask    <= '1;
      cmd_err <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= 8'h00;
    end else begin
      if (frame_start) state <= IDLE;
      if (rx_valid) begin
        // A frame_start in the same cycle aborts first, so the byte is a fresh command.
        if (state == WAIT_DATA && !frame_start) begin
          state <= IDLE;
          case (lat_op)
            OP_WRITE_RAW, OP_WRITE_HEX: begin
              if (idx_ok) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (lat_idx == 4'(i)) begin
                    digit_buf[i] <= (lat_op == OP_WRITE_RAW) ? rx_data
                                                             : {rx_data[7], hex7(rx_data[3:0])};
                  end
                end
              end else begin
                cmd_err <= 1'b1;
              end
            end
            OP_SET_MASK: mask <= NUM_DIGITS'(rx_data);
            default: ;
          endcase
        end else begin
          case (rx_data[7:4])
            OP_CLEAR_ERR: cmd_err <= 1'b0;
            OP_BLANK_ALL: begin
              for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= 8'h00;
            end
            OP_WRITE_RAW, OP_WRITE_HEX, OP_SET_MASK: begin
              lat_op  <= rx_data[7:4];
              lat_idx <= rx_data[3:0];
              state   <= WAIT_DATA;
            end
            default: cmd_err <= 1'b1;
          endcase
        end
      end
    end
  end

  // Scan timebase and registered display outputs. Masked digits keep driving
  // seg/dp from the buffer; only their enable is suppressed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      seg      <= 7'h00;
      dp       <= 1'b0;
      dig_en   <= '0;
    end else begin
      if (scan_cnt == CNTW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDXW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      dig_en <= (NUM_DIGITS'(1) << scan_idx) & mask;
      seg    <= digit_buf[scan_idx][6:0];
      dp     <= digit_buf[scan_idx][7];
    end
  end

endmodule
